axis_pixel_unpacker: RTL and testbench



---
 rtl/axis_pixel_unpacker_pkg.sv | 16 +
 rtl/axis_frame_checker.sv | 55 +++++
 rtl/axis_pixel_unpacker.sv | 115 +++++++++++
 tb/tb_axis_pixel_unpacker.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/axis_pixel_unpacker_pkg.sv
// Shared types and constants for the AXI-Stream word-to-pixel unpacker.
package axis_pixel_unpacker_pkg;

  // Hold-register occupancy: EMPTY waits for a word, SERVE emits its beats.
  typedef enum logic {EMPTY = 1'b0, SERVE = 1'b1} unpack_state_t;

  // Default VGA active area (640x480).
  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;

  // Number of pixel beats carried by one input word.
  function automatic int beats_per_word(input int in_w, input int out_w);
    return in_w / out_w;
  endfunction

endpackage

// File: rtl/axis_frame_checker.sv
// Frame-length checker: counts output beats and flags frames whose TLAST
// arrives early (err_short_o) or late (err_long_o). Both flags are sticky.
module axis_frame_checker #(
  parameter int FRAME_PIXELS = 307200
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic beat_i,
  input  logic last_i,
  output logic err_short_o,
  output logic err_long_o
);

  localparam int CNT_W = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FRAME_PIXELS - 1);

  logic [CNT_W-1:0] pix_cnt_q, pix_cnt_d;
  logic             short_q, short_d;
  logic             long_q, long_d;

  // Next-state: restart the count on TLAST or on overrun; never stall data.
  always_comb begin
    pix_cnt_d = pix_cnt_q;
    short_d   = short_q;
    long_d    = long_q;
    if (beat_i) begin
      if (last_i) begin
        pix_cnt_d = '0;
        if (pix_cnt_q != CNT_MAX) short_d = 1'b1;
      end else if (pix_cnt_q == CNT_MAX) begin
        pix_cnt_d = '0;
        long_d    = 1'b1;
      end else begin
        pix_cnt_d = pix_cnt_q + CNT_W'(1);
      end
    end
  end

  // Counter and sticky flag registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pix_cnt_q <= '0;
      short_q   <= 1'b0;
      long_q    <= 1'b0;
    end else begin
      pix_cnt_q <= pix_cnt_d;
      short_q   <= short_d;
      long_q    <= long_d;
    end
  end

  assign err_short_o = short_q;
  assign err_long_o  = long_q;

endmodule

// File: rtl/axis_pixel_unpacker.sv
// Unpacks IN_WIDTH-bit DMA words into OUT_WIDTH-bit pixel beats, LSB first,
// at one beat per cycle with a same-cycle reload on the final beat.
// Optional frame-length checking is enabled by defining
// AXIS_PIXEL_UNPACKER_FRAME_CHECK_EN; otherwise ERR_SHORT/ERR_LONG are 0.
module axis_pixel_unpacker
  import axis_pixel_unpacker_pkg::*;
#(
  parameter int IN_WIDTH     = 32,
  parameter int OUT_WIDTH    = 8,
  parameter int FRAME_PIXELS = H_ACTIVE * V_ACTIVE
) (
  input  logic                 i_CLK,
  input  logic                 i_RST,
  input  logic [IN_WIDTH-1:0]  S_AXIS_DATA,
  input  logic                 S_AXIS_VALID,
  input  logic                 S_AXIS_LAST,
  output logic                 S_AXIS_READY,
  output logic [OUT_WIDTH-1:0] M_AXIS_DATA,
  output logic                 M_AXIS_VALID,
  output logic                 M_AXIS_LAST,
  input  logic                 M_AXIS_READY,
  output logic                 FRAME_DONE,
  output logic                 ERR_SHORT,
  output logic                 ERR_LONG
);

  localparam int N     = beats_per_word(IN_WIDTH, OUT_WIDTH);
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

  if ((IN_WIDTH % OUT_WIDTH) != 0 || N < 1 || FRAME_PIXELS < 1) begin : g_param_check
    $error("axis_pixel_unpacker: IN_WIDTH must be a multiple of OUT_WIDTH and FRAME_PIXELS >= 1");
  end

  unpack_state_t                    state_q, state_d;
  logic [N-1:0][OUT_WIDTH-1:0]      hold_q, hold_d;
  logic                             last_q, last_d;
  logic [IDX_W-1:0]                 idx_q, idx_d;
  logic                             frame_done_q;

  logic hold_v, idx_end, beat, load;

  assign hold_v  = (state_q == SERVE);
  assign idx_end = (idx_q == IDX_LAST);
  assign beat    = hold_v && M_AXIS_READY;

  // Accept a word when empty, or when the final beat leaves this cycle.
  assign S_AXIS_READY = !hold_v || (idx_end && M_AXIS_READY);
  assign load         = S_AXIS_VALID && S_AXIS_READY;

  assign M_AXIS_VALID = hold_v;
  assign M_AXIS_DATA  = hold_q[idx_q];
  assign M_AXIS_LAST  = last_q && idx_end;
  assign FRAME_DONE   = frame_done_q;

  // Next-state: advance the beat index; a load overrides the drain to EMPTY.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    last_d  = last_q;
    idx_d   = idx_q;
    if (beat) begin
      if (idx_end) begin
        idx_d   = '0;
        state_d = EMPTY;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end
    if (load) begin
      hold_d  = S_AXIS_DATA;
      last_d  = S_AXIS_LAST;
      idx_d   = '0;
      state_d = SERVE;
    end
  end

  // State register.
  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) state_q <= EMPTY;
    else       state_q <= state_d;
  end

  // Hold register, beat index and frame-done pulse.
  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      hold_q       <= '0;
      last_q       <= 1'b0;
      idx_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      hold_q       <= hold_d;
      last_q       <= last_d;
      idx_q        <= idx_d;
      frame_done_q <= beat && M_AXIS_LAST;
    end
  end

`ifdef AXIS_PIXEL_UNPACKER_FRAME_CHECK_EN
  axis_frame_checker #(
    .FRAME_PIXELS(FRAME_PIXELS)
  ) u_frame_checker (
    .clk_i       (i_CLK),
    .rst_i       (i_RST),
    .beat_i      (beat),
    .last_i      (M_AXIS_LAST),
    .err_short_o (ERR_SHORT),
    .err_long_o  (ERR_LONG)
  );
`else
  assign ERR_SHORT = 1'b0;
  assign ERR_LONG  = 1'b0;
`endif

endmodule

// File: tb/tb_axis_pixel_unpacker.sv
// Directed bench for axis_pixel_unpacker (32 -> 8, FRAME_PIXELS = 8).
module tb_axis_pixel_unpacker;

`ifdef AXIS_PIXEL_UNPACKER_FRAME_CHECK_EN
  localparam logic FC = 1'b1;
`else
  localparam logic FC = 1'b0;
`endif
  localparam int CYC_LIMIT = 20000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] s_data = '0;
  logic        s_valid = 1'b0, s_last = 1'b0, s_ready;
  logic [7:0]  m_data;
  logic        m_valid, m_last, m_ready = 1'b0;
  logic        frame_done, err_short, err_long;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  axis_pixel_unpacker #(
    .IN_WIDTH(32), .OUT_WIDTH(8), .FRAME_PIXELS(8)
  ) dut (
    .i_CLK(clk), .i_RST(rst),
    .S_AXIS_DATA(s_data), .S_AXIS_VALID(s_valid), .S_AXIS_LAST(s_last), .S_AXIS_READY(s_ready),
    .M_AXIS_DATA(m_data), .M_AXIS_VALID(m_valid), .M_AXIS_LAST(m_last), .M_AXIS_READY(m_ready),
    .FRAME_DONE(frame_done), .ERR_SHORT(err_short), .ERR_LONG(err_long)
  );

  typedef struct {
    logic        sv;
    logic [31:0] sd;
    logic        sl;
    logic        mr;
    logic        e_sr;
    logic        e_mv;
    logic [7:0]  e_md;
    logic        e_ml;
    logic        e_fd;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_s_ready"}, s_ready, 1);
    chk({tag, "_m_valid"}, m_valid, 0);
    chk({tag, "_m_data"}, m_data, 0);
    chk({tag, "_m_last"}, m_last, 0);
    chk({tag, "_frame_done"}, frame_done, 0);
    chk({tag, "_err_short"}, err_short, 0);
    chk({tag, "_err_long"}, err_long, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = '0; m_ready = 1'b0;
    @(negedge clk); #1;
    chk_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Scoreboarded stream: words are unpacked LSB first into an expected queue.
  task automatic run(input int nwords, input int last_word, input bit rnd, output int nbeats);
    logic [31:0] words[$];
    bit          lasts[$];
    logic [8:0]  exp_q[$];
    logic [8:0]  e;
    logic [31:0] w;
    int sent = 0, got = 0, cyc = 0;
    bit acc = 0;
    for (int i = 0; i < nwords; i++) begin
      words.push_back($urandom);
      lasts.push_back(last_word == -2 ? ($urandom_range(0, 7) == 0) : (i == last_word));
    end
    while ((sent < nwords || got < 4 * nwords) && cyc < CYC_LIMIT) begin
      @(negedge clk);
      cyc++;
      if (acc) s_valid = 1'b0;
      acc = 0;
      if (!s_valid && sent < nwords && (!rnd || $urandom_range(0, 3) != 0)) begin
        s_valid = 1'b1; s_data = words[sent]; s_last = lasts[sent];
      end
      m_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      #1;
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", {23'd0, m_last, m_data}, 32'h1ff00);
        end else begin
          e = exp_q.pop_front();
          chk("beat_data", m_data, e[7:0]);
          chk("beat_last", m_last, e[8]);
        end
        got++;
      end
      if (s_valid && s_ready) begin
        w = words[sent];
        for (int b = 0; b < 4; b++) exp_q.push_back({lasts[sent] && (b == 3), w[8*b +: 8]});
        sent++;
        acc = 1;
      end
    end
    chk("stream_beats_delivered", got, 4 * nwords);
    @(negedge clk);
    s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b1;
    #1;
    chk("stream_drained", m_valid, 0);
    nbeats = got;
  endtask

  function automatic vec_t mk(logic sv, logic [31:0] sd, logic sl, logic mr,
                              logic e_sr, logic e_mv, logic [7:0] e_md, logic e_ml, logic e_fd);
    vec_t v;
    v.sv = sv; v.sd = sd; v.sl = sl; v.mr = mr;
    v.e_sr = e_sr; v.e_mv = e_mv; v.e_md = e_md; v.e_ml = e_ml; v.e_fd = e_fd;
    return v;
  endfunction

  vec_t tv[$];
  int   nb;

  initial begin
    // Back-to-back words at full throughput.
    tv.push_back(mk(1, 32'h44332211, 0, 1, 1, 0, 8'h00, 0, 0));
    tv.push_back(mk(1, 32'h88776655, 0, 1, 0, 1, 8'h11, 0, 0));
    tv.push_back(mk(1, 32'h88776655, 0, 1, 0, 1, 8'h22, 0, 0));
    tv.push_back(mk(1, 32'h88776655, 0, 1, 0, 1, 8'h33, 0, 0));
    tv.push_back(mk(1, 32'h88776655, 0, 1, 1, 1, 8'h44, 0, 0));
    tv.push_back(mk(0, 32'h0,        0, 1, 0, 1, 8'h55, 0, 0));
    tv.push_back(mk(0, 32'h0,        0, 1, 0, 1, 8'h66, 0, 0));
    tv.push_back(mk(0, 32'h0,        0, 1, 0, 1, 8'h77, 0, 0));
    tv.push_back(mk(0, 32'h0,        0, 1, 1, 1, 8'h88, 0, 0));
    tv.push_back(mk(0, 32'h0,        0, 1, 1, 0, 8'h00, 0, 0));
    // TLAST word with alternating back-pressure.
    tv.push_back(mk(1, 32'hDDCCBBAA, 1, 1, 1, 0, 8'h00, 0, 0));
    tv.push_back(mk(0, 32'h0,        0, 1, 0, 1, 8'hAA, 0, 0));
    tv.push_back(mk(0, 32'h0,        0, 0, 0, 1, 8'hBB, 0, 0));
    tv.push_back(mk(0, 32'h0,        0, 1, 0, 1, 8'hBB, 0, 0));
    tv.push_back(mk(0, 32'h0,        0, 0, 0, 1, 8'hCC, 0, 0));
    tv.push_back(mk(0, 32'h0,        0, 1, 0, 1, 8'hCC, 0, 0));
    tv.push_back(mk(0, 32'h0,        0, 0, 0, 1, 8'hDD, 1, 0));
    tv.push_back(mk(0, 32'h0,        0, 1, 1, 1, 8'hDD, 1, 0));
    tv.push_back(mk(0, 32'h0,        0, 1, 1, 0, 8'h00, 0, 1));
    tv.push_back(mk(0, 32'h0,        0, 1, 1, 0, 8'h00, 0, 0));

    do_reset();
    foreach (tv[i]) begin
      @(negedge clk);
      s_valid = tv[i].sv; s_data = tv[i].sd; s_last = tv[i].sl; m_ready = tv[i].mr;
      #1;
      chk($sformatf("v%0d_s_ready", i), s_ready, tv[i].e_sr);
      chk($sformatf("v%0d_m_valid", i), m_valid, tv[i].e_mv);
      if (tv[i].e_mv) begin
        chk($sformatf("v%0d_m_data", i), m_data, tv[i].e_md);
        chk($sformatf("v%0d_m_last", i), m_last, tv[i].e_ml);
      end
      chk($sformatf("v%0d_frame_done", i), frame_done, tv[i].e_fd);
    end

    // Correct 8-beat frame.
    do_reset();
    run(2, 1, 0, nb);
    chk("good_frame_err_short", err_short, 0);
    chk("good_frame_err_long", err_long, 0);

    // Early TLAST after 4 beats; flag is sticky.
    do_reset();
    run(1, 0, 0, nb);
    chk("short_frame_err_short", err_short, FC);
    chk("short_frame_err_long", err_long, 0);
    repeat (3) @(negedge clk);
    #1;
    chk("short_frame_sticky", err_short, FC);

    // TLAST after 12 beats: overrun at beat 8, then a 4-beat short frame.
    do_reset();
    run(3, 2, 0, nb);
    chk("long_frame_beats", nb, 12);
    chk("long_frame_err_long", err_long, FC);
    chk("long_frame_err_short", err_short, FC);

    // Asynchronous reset mid-word, after byte 0x22 has gone out.
    @(negedge clk);
    s_valid = 1'b1; s_data = 32'h44332211; s_last = 1'b0; m_ready = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    m_ready = 1'b0;
    #1;
    chk("mid_word_data", m_data, 8'h33);
    #1;
    rst = 1'b1;
    #1;
    chk_reset_outputs("async_reset");
    @(negedge clk);
    rst = 1'b0;
    run(2, 1, 0, nb);
    chk("after_reset_err_short", err_short, 0);
    chk("after_reset_err_long", err_long, 0);

    // Random handshakes over 1000 words.
    do_reset();
    run(1000, -2, 1, nb);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
